// File: rtl/flash_cmd_seq_ctrl.sv
// JEDEC command-sequence gate for the PRG flash write enable: it tracks the unlock/command
// sequence, times program/erase operations in M2 cycles and reports busy/op/autoselect status.
module flash_cmd_seq_ctrl #(
    parameter logic [10:0] UNLOCK_A1     = 11'h555,
    parameter logic [10:0] UNLOCK_A2     = 11'h2AA,
    parameter int          CNT_W         = 22,
    parameter int          PROG_CYCLES   = 64,
    parameter int          SECTOR_CYCLES = 1800000,
    parameter int          CHIP_CYCLES   = 4194303
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        prg_write_enabled,
    input  logic        wr_strobe,
    input  logic [10:0] flash_addr,
    input  logic [7:0]  wr_data,
    input  logic        err_clr,
    output logic        flash_we_allow,
    output logic        busy,
    output logic [1:0]  op,
    output logic        autoselect,
    output logic        done,
    output logic        seq_error,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_U1      = 4'd1,
        S_U2      = 4'd2,
        S_PARM    = 4'd3,
        S_E0      = 4'd4,
        S_E1      = 4'd5,
        S_E2      = 4'd6,
        S_AUTOSEL = 4'd7,
        S_BUSY    = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] PROG_LOAD   = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] SECTOR_LOAD = CNT_W'(SECTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHIP_LOAD   = CNT_W'(CHIP_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [1:0]       r_op;
    logic             r_autosel;
    logic             r_done;
    logic             r_seq_error;

    logic w_at_a1;
    logic w_at_a2;
    logic w_is_f0;
    logic w_match;
    logic w_err_set;

    assign w_at_a1 = (flash_addr == UNLOCK_A1);
    assign w_at_a2 = (flash_addr == UNLOCK_A2);
    assign w_is_f0 = (wr_data == 8'hF0);

    // w_match: the write is the step the current state is waiting for.
    always_comb begin
        w_match = 1'b0;
        case (r_state)
            S_IDLE:  w_match = w_at_a1 & (wr_data == 8'hAA);
            S_U1:    w_match = w_at_a2 & (wr_data == 8'h55);
            S_U2:    w_match = w_at_a1 & ((wr_data == 8'hA0) | (wr_data == 8'h80) | (wr_data == 8'h90));
            S_PARM:  w_match = 1'b1;
            S_E0:    w_match = w_at_a1 & (wr_data == 8'hAA);
            S_E1:    w_match = w_at_a2 & (wr_data == 8'h55);
            S_E2:    w_match = (wr_data == 8'h30) | (w_at_a1 & (wr_data == 8'h10));
            default: w_match = 1'b0;
        endcase
    end

    assign flash_we_allow = prg_write_enabled & wr_strobe & (r_state != S_BUSY) & (w_match | w_is_f0);

    // Stray writes in IDLE are ordinary mapper register writes and never count as errors.
    assign w_err_set = wr_strobe & ((r_state == S_BUSY) |
                       (prg_write_enabled & (r_state != S_IDLE) & ~w_match & ~w_is_f0));

    always_ff @(posedge m2) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_op        <= 2'b00;
            r_autosel   <= 1'b0;
            r_done      <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_seq_error <= w_err_set | (r_seq_error & ~err_clr);
            r_done      <= 1'b0;
            if (r_state == S_BUSY) begin
                if (r_cnt == '0) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_op    <= 2'b00;
                    r_done  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end else if (!prg_write_enabled) begin
                r_state   <= S_IDLE;
                r_autosel <= 1'b0;
            end else if (wr_strobe) begin
                if (!w_match) begin
                    // AUTOSEL is left only by F0; everything else falls back to IDLE.
                    if ((r_state != S_AUTOSEL) || w_is_f0) begin
                        r_state   <= S_IDLE;
                        r_autosel <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        S_IDLE: r_state <= S_U1;
                        S_U1:   r_state <= S_U2;
                        S_U2: begin
                            if (wr_data == 8'hA0) begin
                                r_state <= S_PARM;
                            end else if (wr_data == 8'h80) begin
                                r_state <= S_E0;
                            end else begin
                                r_state   <= S_AUTOSEL;
                                r_autosel <= 1'b1;
                            end
                        end
                        S_PARM: begin
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            r_op    <= 2'b01;
                            r_cnt   <= PROG_LOAD;
                        end
                        S_E0:   r_state <= S_E1;
                        S_E1:   r_state <= S_E2;
                        S_E2: begin
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            if (wr_data == 8'h30) begin
                                r_op  <= 2'b10;
                                r_cnt <= SECTOR_LOAD;
                            end else begin
                                r_op  <= 2'b11;
                                r_cnt <= CHIP_LOAD;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign busy       = r_busy;
    assign op         = r_op;
    assign autoselect = r_autosel;
    assign done       = r_done;
    assign seq_error  = r_seq_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_flash_cmd_seq_ctrl.sv
// Bench for flash_cmd_seq_ctrl: directed scenarios plus randomized traffic checked
// against a command-sequence prefix model.
module tb_flash_cmd_seq_ctrl;

    localparam int PROG_C = 64;
    localparam int SECT_C = 100;
    localparam int CHIP_C = 200;

    logic        m2 = 1'b0;
    logic        rst_n = 1'b0;
    logic        prg_write_enabled = 1'b0;
    logic        wr_strobe = 1'b0;
    logic [10:0] flash_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        err_clr = 1'b0;
    logic        flash_we_allow;
    logic        busy;
    logic [1:0]  op;
    logic        autoselect;
    logic        done;
    logic        seq_error;
    logic [3:0]  dbg_state;

    always #5 m2 = ~m2;

    flash_cmd_seq_ctrl #(
        .PROG_CYCLES  (PROG_C),
        .SECTOR_CYCLES(SECT_C),
        .CHIP_CYCLES  (CHIP_C)
    ) dut (
        .m2               (m2),
        .rst_n            (rst_n),
        .prg_write_enabled(prg_write_enabled),
        .wr_strobe        (wr_strobe),
        .flash_addr       (flash_addr),
        .wr_data          (wr_data),
        .err_clr          (err_clr),
        .flash_we_allow   (flash_we_allow),
        .busy             (busy),
        .op               (op),
        .autoselect       (autoselect),
        .done             (done),
        .seq_error        (seq_error),
        .dbg_state        (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       obs_allow, obs_busy, obs_auto, obs_done, obs_err, obs_idle;
    logic [1:0] obs_op;

    // Reference model: valid command sequences as (data, addr) lists, -1 = any value.
    // 0 program, 1 sector erase, 2 chip erase, 3 autoselect entry.
    int seq_len[4];
    int seq_d[4][6];
    int seq_a[4][6];

    int         m_left;
    int         m_op;
    bit         m_auto, m_done, m_err;
    logic [7:0]  hd[$];
    logic [10:0] ha[$];
    bit         exp_allow;

    function automatic bit m_idle();
        return (m_left == 0) && !m_auto && (hd.size() == 0);
    endfunction

    // Index of the sequence that history plus this write is a prefix of, or -1.
    function automatic int match_seq(input logic [7:0] d, input logic [10:0] a);
        int n;
        bit ok;
        n = hd.size();
        for (int s = 0; s < 4; s++) begin
            if (n + 1 <= seq_len[s]) begin
                ok = 1'b1;
                for (int i = 0; i <= n; i++) begin
                    logic [7:0]  cd;
                    logic [10:0] ca;
                    cd = (i == n) ? d : hd[i];
                    ca = (i == n) ? a : ha[i];
                    if (seq_d[s][i] >= 0 && seq_d[s][i] != int'(cd)) ok = 1'b0;
                    if (seq_a[s][i] >= 0 && seq_a[s][i] != int'(ca)) ok = 1'b0;
                end
                if (ok) return s;
            end
        end
        return -1;
    endfunction

    function automatic bit model_allow(input bit stb, input logic [10:0] a, input logic [7:0] d, input bit pwe);
        if (m_left > 0 || !stb || !pwe) return 1'b0;
        if (d == 8'hF0) return 1'b1;
        if (m_auto) return 1'b0;
        return match_seq(d, a) >= 0;
    endfunction

    task automatic model_edge(input bit rst, input bit stb, input logic [10:0] a,
                              input logic [7:0] d, input bit pwe, input bit clr);
        bit err_new;
        int s;
        err_new = 1'b0;
        m_done  = 1'b0;
        if (!rst) begin
            m_left = 0; m_op = 0; m_auto = 1'b0; m_err = 1'b0;
            hd.delete(); ha.delete();
        end else begin
            if (m_left > 0) begin
                if (stb) err_new = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_op = 0;
                    m_done = 1'b1;
                end
            end else if (!pwe) begin
                m_auto = 1'b0;
                hd.delete(); ha.delete();
            end else if (stb) begin
                if (m_auto) begin
                    if (d == 8'hF0) m_auto = 1'b0;
                    else err_new = 1'b1;
                end else begin
                    s = match_seq(d, a);
                    if (s >= 0) begin
                        hd.push_back(d); ha.push_back(a);
                        if (hd.size() == seq_len[s]) begin
                            hd.delete(); ha.delete();
                            if (s == 3) begin
                                m_auto = 1'b1;
                            end else begin
                                m_op   = s + 1;
                                m_left = (s == 0) ? PROG_C : (s == 1) ? SECT_C : CHIP_C;
                            end
                        end
                    end else begin
                        if (hd.size() != 0 && d != 8'hF0) err_new = 1'b1;
                        hd.delete(); ha.delete();
                    end
                end
            end
            m_err = err_new | (m_err & !clr);
        end
    endtask

    // Drive one M2 cycle: inputs at negedge, allow sampled before the edge, registers after it.
    task automatic cycle(input bit rst, input bit stb, input logic [10:0] a,
                         input logic [7:0] d, input bit pwe, input bit clr);
        @(negedge m2);
        rst_n = rst; wr_strobe = stb; flash_addr = a; wr_data = d;
        prg_write_enabled = pwe; err_clr = clr;
        #1;
        obs_allow = flash_we_allow;
        exp_allow = model_allow(stb, a, d, pwe);
        @(posedge m2);
        #1;
        model_edge(rst, stb, a, d, pwe, clr);
        obs_busy = busy; obs_op = op; obs_auto = autoselect;
        obs_done = done; obs_err = seq_error; obs_idle = (dbg_state == 4'd0);
    endtask

    task automatic idle_cycle();
        cycle(1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if ({obs_busy, obs_op, obs_auto, obs_done, obs_err, obs_idle} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b op=%b auto=%b done=%b err=%b idle=%b, want 0/00/0/0/0/1",
                     obs_busy, obs_op, obs_auto, obs_done, obs_err, obs_idle);
        end
    endtask

    task automatic test_mapper_write();
        cycle(1'b1, 1'b1, 11'h000, 8'h05, 1'b1, 1'b0);
        n_tests++;
        if ({obs_allow, obs_idle, obs_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL mapper_write: got allow=%b idle=%b err=%b, want 0/1/0", obs_allow, obs_idle, obs_err);
        end
    endtask

    task automatic test_program();
        logic [7:0]  d[4];
        logic [10:0] a[4];
        int n, bad;
        d = '{8'hAA, 8'h55, 8'hA0, 8'h3C};
        a = '{11'h555, 11'h2AA, 11'h555, 11'h123};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, a[i], d[i], 1'b1, 1'b0);
            n_tests++;
            if (obs_allow !== 1'b1) begin
                n_fail++;
                $display("FAIL program_allow_%0d: got %b want 1", i, obs_allow);
            end
        end
        n_tests++;
        if ({obs_busy, obs_op} !== 3'b101) begin
            n_fail++;
            $display("FAIL program_start: got busy=%b op=%b want 1/01", obs_busy, obs_op);
        end
        n = 0; bad = 0;
        while (n < 300) begin
            idle_cycle();
            n++;
            if (obs_done) break;
            if (obs_busy !== 1'b1 || obs_op !== 2'b01) bad++;
        end
        n_tests++;
        if (n != PROG_C || obs_busy !== 1'b0 || bad != 0) begin
            n_fail++;
            $display("FAIL program_duration: got %0d cycles busy=%b glitches=%0d, want %0d/0/0", n, obs_busy, bad, PROG_C);
        end
        idle_cycle();
        n_tests++;
        if (obs_done !== 1'b0) begin
            n_fail++;
            $display("FAIL program_done_pulse: got done=%b want 0", obs_done);
        end
    endtask

    task automatic test_sector_erase();
        logic [7:0]  d[6];
        logic [10:0] a[6];
        int n;
        d = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
        a = '{11'h555, 11'h2AA, 11'h555, 11'h555, 11'h2AA, 11'h000};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, a[i], d[i], 1'b1, 1'b0);
            n_tests++;
            if (obs_allow !== 1'b1) begin
                n_fail++;
                $display("FAIL sector_allow_%0d: got %b want 1", i, obs_allow);
            end
        end
        n_tests++;
        if ({obs_busy, obs_op} !== 3'b110) begin
            n_fail++;
            $display("FAIL sector_start: got busy=%b op=%b want 1/10", obs_busy, obs_op);
        end
        cycle(1'b1, 1'b1, 11'h555, 8'h12, 1'b1, 1'b0);
        n_tests++;
        if ({obs_allow, obs_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL sector_busy_write: got allow=%b err=%b want 0/1", obs_allow, obs_err);
        end
        cycle(1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1);
        n_tests++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sector_err_clr: got err=%b want 0", obs_err);
        end
        n = 2;
        while (n < 400 && !obs_done) begin
            idle_cycle();
            n++;
        end
        n_tests++;
        if (n != SECT_C || obs_busy !== 1'b0 || obs_op !== 2'b00) begin
            n_fail++;
            $display("FAIL sector_duration: got %0d cycles busy=%b op=%b want %0d/0/00", n, obs_busy, obs_op, SECT_C);
        end
    endtask

    task automatic test_autoselect();
        cycle(1'b1, 1'b1, 11'h555, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h2AA, 8'h55, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h555, 8'h90, 1'b1, 1'b0);
        n_tests++;
        if (obs_auto !== 1'b1) begin
            n_fail++;
            $display("FAIL autosel_enter: got %b want 1", obs_auto);
        end
        cycle(1'b1, 1'b1, 11'h000, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({obs_allow, obs_err, obs_auto} !== 3'b011) begin
            n_fail++;
            $display("FAIL autosel_block: got allow=%b err=%b auto=%b want 0/1/1", obs_allow, obs_err, obs_auto);
        end
        cycle(1'b1, 1'b1, 11'h000, 8'hF0, 1'b1, 1'b1);
        n_tests++;
        if ({obs_allow, obs_auto, obs_idle, obs_err} !== 4'b1010) begin
            n_fail++;
            $display("FAIL autosel_exit: got allow=%b auto=%b idle=%b err=%b want 1/0/1/0", obs_allow, obs_auto, obs_idle, obs_err);
        end
    endtask

    task automatic test_abort();
        cycle(1'b1, 1'b1, 11'h555, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h2AA, 8'h56, 1'b1, 1'b1);
        n_tests++;
        if ({obs_allow, obs_idle, obs_err} !== 3'b011) begin
            n_fail++;
            $display("FAIL abort_seq: got allow=%b idle=%b err=%b want 0/1/1", obs_allow, obs_idle, obs_err);
        end
        cycle(1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 11'h555, 8'hAA, 1'b0, 1'b0);
        n_tests++;
        if (obs_allow !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pwe0_first: got allow=%b want 0", obs_allow);
        end
        cycle(1'b1, 1'b1, 11'h2AA, 8'h56, 1'b0, 1'b0);
        n_tests++;
        if ({obs_allow, obs_idle, obs_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_pwe0_second: got allow=%b idle=%b err=%b want 0/1/0", obs_allow, obs_idle, obs_err);
        end
    endtask

    task automatic test_busy_end_write();
        cycle(1'b1, 1'b1, 11'h555, 8'hAA, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h2AA, 8'h55, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h555, 8'hA0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 11'h042, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < PROG_C - 1; i++) idle_cycle();
        cycle(1'b1, 1'b1, 11'h000, 8'hF0, 1'b1, 1'b0);
        n_tests++;
        if ({obs_allow, obs_busy, obs_done, obs_err, obs_idle} !== 5'b00111) begin
            n_fail++;
            $display("FAIL busy_end_write: got allow=%b busy=%b done=%b err=%b idle=%b want 0/0/1/1/1",
                     obs_allow, obs_busy, obs_done, obs_err, obs_idle);
        end
        cycle(1'b1, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        logic [7:0]  d[6];
        logic [10:0] a[6];
        d = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h10};
        a = '{11'h555, 11'h2AA, 11'h555, 11'h555, 11'h2AA, 11'h555};
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, a[i], d[i], 1'b1, 1'b0);
        n_tests++;
        if ({obs_busy, obs_op} !== 3'b111) begin
            n_fail++;
            $display("FAIL chip_start: got busy=%b op=%b want 1/11", obs_busy, obs_op);
        end
        for (int i = 0; i < 10; i++) idle_cycle();
        cycle(1'b0, 1'b0, 11'h000, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({obs_busy, obs_op, obs_done, obs_idle} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b op=%b done=%b idle=%b want 0/00/0/1", obs_busy, obs_op, obs_done, obs_idle);
        end
    endtask

    task automatic test_random();
        bit rst, stb, pwe, clr;
        logic [10:0] a;
        logic [7:0]  d;
        int s, k;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            pwe = ($urandom_range(0, 19) != 0);
            stb = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 9) == 0);
            a = 11'($urandom_range(0, 2047));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 6) begin
                s = $urandom_range(0, 3);
                k = hd.size();
                if (k < seq_len[s]) begin
                    if (seq_d[s][k] >= 0) d = 8'(seq_d[s][k]);
                    if (seq_a[s][k] >= 0) a = 11'(seq_a[s][k]);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d = 8'hF0;
            end
            cycle(rst, stb, a, d, pwe, clr);
            n_tests++;
            if (obs_allow !== exp_allow || obs_busy !== (m_left > 0) || obs_op !== 2'(m_op) ||
                obs_auto !== m_auto || obs_done !== m_done || obs_err !== m_err || obs_idle !== m_idle()) begin
                n_fail++;
                $display("FAIL random_%0d: got allow=%b busy=%b op=%b auto=%b done=%b err=%b idle=%b want %b/%b/%0d/%b/%b/%b/%b",
                         c, obs_allow, obs_busy, obs_op, obs_auto, obs_done, obs_err, obs_idle,
                         exp_allow, (m_left > 0), m_op, m_auto, m_done, m_err, m_idle());
            end
        end
    endtask

    initial begin
        seq_len = '{4, 6, 6, 3};
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 6; i++) begin
                seq_d[s][i] = -1;
                seq_a[s][i] = -1;
            end
            seq_d[s][0] = 'hAA; seq_a[s][0] = 'h555;
            seq_d[s][1] = 'h55; seq_a[s][1] = 'h2AA;
        end
        seq_d[0][2] = 'hA0; seq_a[0][2] = 'h555;
        for (int s = 1; s < 3; s++) begin
            seq_d[s][2] = 'h80; seq_a[s][2] = 'h555;
            seq_d[s][3] = 'hAA; seq_a[s][3] = 'h555;
            seq_d[s][4] = 'h55; seq_a[s][4] = 'h2AA;
        end
        seq_d[1][5] = 'h30;
        seq_d[2][5] = 'h10; seq_a[2][5] = 'h555;
        seq_d[3][2] = 'h90; seq_a[3][2] = 'h555;

        test_reset();
        test_mapper_write();
        test_program();
        test_sector_erase();
        test_autoselect();
        test_abort();
        test_busy_end_write();
        test_reset_mid_op();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
